// File: rtl/imem_loader_if.sv
// Byte-stream and instruction-memory write bus of imem_loader.
// The loader takes the slave side; whoever feeds bytes takes the master side.
interface imem_loader_if;
    logic        start;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wd;
    logic        cpu_rst_n;
    logic        busy;
    logic        done;
    logic        error;

    modport master (
        output start, rx_valid, rx_data,
        input  rx_ready, imem_we, imem_addr, imem_wd, cpu_rst_n, busy, done, error
    );

    modport slave (
        input  start, rx_valid, rx_data,
        output rx_ready, imem_we, imem_addr, imem_wd, cpu_rst_n, busy, done, error
    );
endinterface

// File: rtl/imem_loader.sv
// Loads a length-prefixed, MSB-first byte stream into instruction memory and holds the CPU in reset until done.
// Optional end-of-load XOR checksum byte: define IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int          IMEM_DEPTH = 64,
    parameter logic [31:0] BASE_ADDR  = 32'd0
) (
    input  logic         clk,
    input  logic         rst_n,
    imem_loader_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LEN   = 3'd1,
        S_BYTE  = 3'd2,
        S_WRITE = 3'd3,
        S_CHK   = 3'd4,
        S_DONE  = 3'd5,
        S_ERR   = 3'd6
    } state_t;

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_t S_LAST = S_CHK;
`else
    localparam state_t S_LAST = S_DONE;
`endif

    localparam logic [8:0] DEPTH_L = 9'(IMEM_DEPTH);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [7:0]  r_len;
    logic [7:0]  r_word_cnt;
    logic [1:0]  r_byte_cnt;
    logic [31:0] r_word;
    logic [31:0] r_addr;
    logic [31:0] r_wd;
    logic        r_rx_ready;
    logic        r_we;
    logic        r_busy;
    logic        r_done;
    logic        r_error;
    logic        r_cpu_rst_n;
    logic        w_accept;
    logic [8:0]  w_word_inc;
    logic        w_rx_ready_nxt;
    logic        w_busy_nxt;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]  r_chk;
`endif

    assign w_accept   = bus.rx_valid & r_rx_ready;
    assign w_word_inc = {1'b0, r_word_cnt} + 9'd1;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic and output decode of the next state, so outputs can be registered in step with the state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_DONE, S_ERR: begin
                if (bus.start) w_state_nxt = S_LEN;
                else           w_state_nxt = r_state;
            end
            S_LEN: begin
                if (!w_accept)                           w_state_nxt = r_state;
                else if (bus.rx_data == 8'd0)            w_state_nxt = S_LAST;
                else if ({1'b0, bus.rx_data} > DEPTH_L)  w_state_nxt = S_ERR;
                else                                     w_state_nxt = S_BYTE;
            end
            S_BYTE: begin
                if (w_accept && (r_byte_cnt == 2'd3)) w_state_nxt = S_WRITE;
                else                                  w_state_nxt = r_state;
            end
            S_WRITE: begin
                if (w_word_inc < {1'b0, r_len}) w_state_nxt = S_BYTE;
                else                            w_state_nxt = S_LAST;
            end
            S_CHK: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                if (!w_accept)                   w_state_nxt = r_state;
                else if (bus.rx_data == r_chk)   w_state_nxt = S_DONE;
                else                             w_state_nxt = S_ERR;
`else
                w_state_nxt = S_ERR;
`endif
            end
            default: w_state_nxt = S_IDLE;
        endcase
        w_rx_ready_nxt = (w_state_nxt == S_LEN) || (w_state_nxt == S_BYTE) || (w_state_nxt == S_CHK);
        w_busy_nxt     = w_rx_ready_nxt || (w_state_nxt == S_WRITE);
    end

    // Registered status/handshake outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rx_ready  <= 1'b0;
            r_we        <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_cpu_rst_n <= 1'b0;
        end else begin
            r_rx_ready  <= w_rx_ready_nxt;
            r_we        <= (w_state_nxt == S_WRITE);
            r_busy      <= w_busy_nxt;
            r_done      <= (w_state_nxt == S_DONE);
            r_error     <= (w_state_nxt == S_ERR);
            r_cpu_rst_n <= (w_state_nxt == S_DONE);
        end
    end

    // Datapath: length capture, byte assembly, write address/data and checksum
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_len      <= 8'd0;
            r_word_cnt <= 8'd0;
            r_byte_cnt <= 2'd0;
            r_word     <= 32'd0;
            r_addr     <= 32'd0;
            r_wd       <= 32'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_chk      <= 8'd0;
`endif
        end else begin
            case (r_state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (bus.start) begin
                        r_word_cnt <= 8'd0;
                        r_byte_cnt <= 2'd0;
                        r_word     <= 32'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        r_chk      <= 8'd0;
`endif
                    end else begin
                        r_word_cnt <= r_word_cnt;
                    end
                end
                S_LEN: begin
                    if (w_accept) r_len <= bus.rx_data;
                    else          r_len <= r_len;
                end
                S_BYTE: begin
                    if (w_accept) begin
                        r_word     <= {r_word[23:0], bus.rx_data};
                        r_byte_cnt <= r_byte_cnt + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        r_chk      <= r_chk ^ bus.rx_data;
`endif
                        // Address and data are latched with the last byte so they are valid throughout WRITE.
                        if (r_byte_cnt == 2'd3) begin
                            r_wd   <= {r_word[23:0], bus.rx_data};
                            r_addr <= BASE_ADDR + {24'd0, r_word_cnt};
                        end else begin
                            r_wd   <= r_wd;
                        end
                    end else begin
                        r_word <= r_word;
                    end
                end
                S_WRITE: r_word_cnt <= r_word_cnt + 8'd1;
                default: r_word_cnt <= r_word_cnt;
            endcase
        end
    end

    assign bus.rx_ready  = r_rx_ready;
    assign bus.imem_we   = r_we;
    assign bus.imem_addr = r_addr;
    assign bus.imem_wd   = r_wd;
    assign bus.cpu_rst_n = r_cpu_rst_n;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.error     = r_error;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: scenario tasks plus a write scoreboard checked by a monitor.
module tb_imem_loader;

    logic clk;
    logic rst_n;
    imem_loader_if bus();

    imem_loader dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_writes = 0;
    logic [63:0] sb[$];

    // Every observed write must match the oldest expected write
    always @(negedge clk) begin
        logic [63:0] e;
        if (bus.imem_we === 1'b1) begin
            n_writes++;
            n_checks++;
            if (sb.size() == 0) begin
                $display("FAIL unexpected_write: got addr=%h wd=%h, expected no write", bus.imem_addr, bus.imem_wd);
            end else begin
                e = sb.pop_front();
                if ({bus.imem_addr, bus.imem_wd} !== e)
                    $display("FAIL write_data: got addr=%h wd=%h, expected addr=%h wd=%h",
                             bus.imem_addr, bus.imem_wd, e[63:32], e[31:0]);
                else
                    n_pass++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        bus.rx_valid = 1'b0;
        repeat (gap) tick();
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        t = 0;
        @(negedge clk);
        while (bus.rx_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) begin
            $display("FAIL rx_timeout: rx_ready stuck at %b, expected 1", bus.rx_ready);
            $fatal(1, "byte not accepted");
        end
        tick();
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'hxx;
    endtask

    // Sends one word; the expected write is queued once its final byte has been accepted
    task automatic send_word(input logic [31:0] addr, input logic [31:0] w, input int gap);
        send_byte(w[31:24], gap);
        send_byte(w[23:16], gap);
        send_byte(w[15:8],  gap);
        send_byte(w[7:0],   gap);
        sb.push_back({addr, w});
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data = 8'h00;
        tick();
        tick();
        n_checks++;
        if ({bus.rx_ready, bus.imem_we, bus.cpu_rst_n, bus.busy, bus.done, bus.error} !== 6'b000000)
            $display("FAIL reset_flags: got rdy/we/cpu/busy/done/err=%b, expected 000000",
                     {bus.rx_ready, bus.imem_we, bus.cpu_rst_n, bus.busy, bus.done, bus.error});
        else n_pass++;
        n_checks++;
        if ({bus.imem_addr, bus.imem_wd} !== 64'd0)
            $display("FAIL reset_bus: got addr=%h wd=%h, expected 0 0", bus.imem_addr, bus.imem_wd);
        else n_pass++;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        logic [31:0] w;
        int wr0;
        w = 32'h2008_0005;
        wr0 = n_writes;
        pulse_start();
        n_checks++;
        if ({bus.busy, bus.rx_ready, bus.cpu_rst_n} !== 3'b110)
            $display("FAIL len_state: got busy/rdy/cpu=%b, expected 110", {bus.busy, bus.rx_ready, bus.cpu_rst_n});
        else n_pass++;
        send_byte(8'd1, 0);
        send_word(32'd0, w, 0);
        n_checks++;
        if (bus.imem_we !== 1'b1)
            $display("FAIL write_latency: got imem_we=%b, expected 1", bus.imem_we);
        else n_pass++;
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0], 0);
`else
        tick();
`endif
        n_checks++;
        if ({bus.done, bus.cpu_rst_n, bus.busy, bus.error} !== 4'b1100)
            $display("FAIL single_done: got done/cpu/busy/err=%b, expected 1100",
                     {bus.done, bus.cpu_rst_n, bus.busy, bus.error});
        else n_pass++;
        n_checks++;
        if ({bus.imem_addr, bus.imem_wd} !== {32'd0, w})
            $display("FAIL hold_bus: got addr=%h wd=%h, expected 0 %h", bus.imem_addr, bus.imem_wd, w);
        else n_pass++;
        n_checks++;
        if (n_writes - wr0 != 1 || sb.size() != 0)
            $display("FAIL single_count: got %0d writes (%0d pending), expected 1 (0)", n_writes - wr0, sb.size());
        else n_pass++;
    endtask

    task automatic test_gaps();
        logic [31:0] words [3];
        logic [7:0] chk;
        int wr0;
        words[0] = 32'h1122_3344;
        words[1] = 32'hDEAD_BEEF;
        words[2] = 32'h0000_FFFF;
        chk = 8'h00;
        wr0 = n_writes;
        pulse_start();
        send_byte(8'd3, 2);
        for (int i = 0; i < 3; i++) begin
            send_word(32'(i), words[i], 2);
            chk = chk ^ words[i][31:24] ^ words[i][23:16] ^ words[i][15:8] ^ words[i][7:0];
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(chk, 2);
`else
        tick();
`endif
        n_checks++;
        if (bus.done !== 1'b1 || n_writes - wr0 != 3 || sb.size() != 0)
            $display("FAIL gaps_result: got done=%b writes=%0d pending=%0d, expected 1 3 0",
                     bus.done, n_writes - wr0, sb.size());
        else n_pass++;
        n_checks++;
        if (bus.imem_addr !== 32'd2)
            $display("FAIL gaps_last_addr: got %h, expected 2", bus.imem_addr);
        else n_pass++;
    endtask

    task automatic test_overflow();
        int wr0;
        wr0 = n_writes;
        pulse_start();
        send_byte(8'd65, 0);
        n_checks++;
        if ({bus.error, bus.busy, bus.cpu_rst_n, bus.rx_ready, bus.done} !== 5'b10000)
            $display("FAIL overflow_err: got err/busy/cpu/rdy/done=%b, expected 10000",
                     {bus.error, bus.busy, bus.cpu_rst_n, bus.rx_ready, bus.done});
        else n_pass++;
        repeat (3) tick();
        n_checks++;
        if (n_writes != wr0 || bus.error !== 1'b1)
            $display("FAIL overflow_nowrite: got writes=%0d err=%b, expected 0 1", n_writes - wr0, bus.error);
        else n_pass++;
    endtask

    task automatic test_zero_len();
        pulse_start();
        send_byte(8'd0, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        n_checks++;
        if ({bus.busy, bus.rx_ready, bus.done} !== 3'b110)
            $display("FAIL zero_chk_state: got busy/rdy/done=%b, expected 110", {bus.busy, bus.rx_ready, bus.done});
        else n_pass++;
        send_byte(8'h00, 0);
`endif
        n_checks++;
        if ({bus.done, bus.cpu_rst_n, bus.busy} !== 3'b110)
            $display("FAIL zero_done: got done/cpu/busy=%b, expected 110", {bus.done, bus.cpu_rst_n, bus.busy});
        else n_pass++;
    endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        pulse_start();
        send_byte(8'd1, 0);
        send_word(32'd0, 32'h0000_0001, 0);
        send_byte(8'h00, 0);
        n_checks++;
        if ({bus.error, bus.done, bus.cpu_rst_n} !== 3'b100)
            $display("FAIL chk_bad: got err/done/cpu=%b, expected 100", {bus.error, bus.done, bus.cpu_rst_n});
        else n_pass++;
        pulse_start();
        send_byte(8'd1, 0);
        send_word(32'd0, 32'h0000_0001, 0);
        send_byte(8'h01, 0);
        n_checks++;
        if ({bus.error, bus.done, bus.cpu_rst_n} !== 3'b011)
            $display("FAIL chk_good: got err/done/cpu=%b, expected 011", {bus.error, bus.done, bus.cpu_rst_n});
        else n_pass++;
    endtask
`endif

    task automatic test_reset_mid();
        int wr0;
        wr0 = n_writes;
        pulse_start();
        send_byte(8'd2, 0);
        send_word(32'd0, 32'hCAFE_0001, 0);
        send_byte(8'h55, 0);
        send_byte(8'h66, 0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n_checks++;
        if ({bus.rx_ready, bus.imem_we, bus.cpu_rst_n, bus.busy, bus.done, bus.error} !== 6'b000000 ||
            {bus.imem_addr, bus.imem_wd} !== 64'd0)
            $display("FAIL midreset_outputs: got flags=%b addr=%h wd=%h, expected 000000 0 0",
                     {bus.rx_ready, bus.imem_we, bus.cpu_rst_n, bus.busy, bus.done, bus.error},
                     bus.imem_addr, bus.imem_wd);
        else n_pass++;
        repeat (3) tick();
        n_checks++;
        if (n_writes - wr0 != 1 || sb.size() != 0)
            $display("FAIL midreset_writes: got %0d writes, expected 1", n_writes - wr0);
        else n_pass++;
        pulse_start();
        send_byte(8'd1, 0);
        send_word(32'd0, 32'hA5A5_0F0F, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(8'hA5 ^ 8'hA5 ^ 8'h0F ^ 8'h0F, 0);
`else
        tick();
`endif
        n_checks++;
        if (bus.done !== 1'b1 || n_writes - wr0 != 2 || sb.size() != 0)
            $display("FAIL midreset_reload: got done=%b writes=%0d, expected 1 2", bus.done, n_writes - wr0);
        else n_pass++;
    endtask

    task automatic test_start_ignored();
        logic [31:0] w0;
        logic [31:0] w1;
        int wr0;
        w0 = 32'h0102_0304;
        w1 = 32'h0506_0708;
        wr0 = n_writes;
        pulse_start();
        send_byte(8'd2, 0);
        send_byte(w0[31:24], 0);
        send_byte(w0[23:16], 0);
        pulse_start();
        send_byte(w0[15:8], 0);
        send_byte(w0[7:0], 0);
        sb.push_back({32'd0, w0});
        send_word(32'd1, w1, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(8'h01 ^ 8'h02 ^ 8'h03 ^ 8'h04 ^ 8'h05 ^ 8'h06 ^ 8'h07 ^ 8'h08, 0);
`else
        tick();
`endif
        n_checks++;
        if (bus.done !== 1'b1 || n_writes - wr0 != 2 || sb.size() != 0)
            $display("FAIL busy_start: got done=%b writes=%0d pending=%0d, expected 1 2 0",
                     bus.done, n_writes - wr0, sb.size());
        else n_pass++;
        pulse_start();
        n_checks++;
        if ({bus.cpu_rst_n, bus.done, bus.busy, bus.rx_ready} !== 4'b0011)
            $display("FAIL done_restart: got cpu/done/busy/rdy=%b, expected 0011",
                     {bus.cpu_rst_n, bus.done, bus.busy, bus.rx_ready});
        else n_pass++;
        send_byte(8'd0, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(8'h00, 0);
`endif
    endtask

    initial begin
        test_reset();
        test_single();
        test_gaps();
        test_overflow();
        test_zero_len();
`ifdef IMEM_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        test_reset_mid();
        test_start_ignored();
        repeat (3) tick();
        n_checks++;
        if (sb.size() != 0)
            $display("FAIL final_scoreboard: got %0d pending writes, expected 0", sb.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter IMEM_DEPTH, default 64, number of 32-bit words in instruction memory; legal 1..255.
REQ-002 Parameter BASE_ADDR, default 0, word address written for the first loaded word.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 start  input  1  one-cycle pulse that begins a load session.
REQ-006 rx_valid  input  1  byte on rx_data is valid.
REQ-007 rx_data  input  8  serial program byte.
REQ-008 rx_ready  output  1  loader accepts a byte this cycle.
REQ-009 imem_we  output  1  instruction-memory write enable.
REQ-010 imem_addr  output  32  word address; consecutive words differ by 1.
REQ-011 imem_wd  output  32  instruction word to write.
REQ-012 cpu_rst_n  output  1  active-low hold for the processor program counter; low except in DONE.
REQ-013 busy, done, error  output  1 each  session in progress / completed OK / aborted.

Function
REQ-014 A byte SHALL be accepted only on a cycle with rx_valid=1 and rx_ready=1; rx_data is ignored otherwise.
REQ-015 States: IDLE, LEN, BYTE, WRITE, CHK, DONE, ERR; rx_ready=1 only in LEN, BYTE and CHK.
REQ-016 IDLE: start=1 -> LEN, word counter and byte counter cleared, checksum cleared.
REQ-017 LEN: accepted byte is word count N; N=0 -> DONE (CHK when CHECKSUM_EN defined); N>IMEM_DEPTH -> ERR; else -> BYTE.
REQ-018 BYTE: four accepted bytes form one word, first byte in bits 31:24 (MSB first); the fourth accepted byte -> WRITE.
REQ-019 WRITE: exactly one cycle with imem_we=1, imem_addr=BASE_ADDR+k (k = 0-based word index), imem_wd=assembled word; then k increments; -> BYTE if k+1<N, else CHK when CHECKSUM_EN defined, else DONE.
REQ-020 Latency: imem_we asserts the cycle after the fourth byte of a word is accepted.
REQ-021 imem_we SHALL be 0 in every state other than WRITE; imem_addr and imem_wd hold their last values outside WRITE.
REQ-022 busy=1 in LEN, BYTE, WRITE, CHK; done=1 only in DONE; error=1 only in ERR.
REQ-023 cpu_rst_n=1 only in DONE, so the processor fetches from BASE_ADDR only after a complete load.
REQ-024 start while busy=1 SHALL be ignored.
REQ-025 start in DONE or ERR SHALL restart exactly as from IDLE; cpu_rst_n falls the following cycle.
REQ-026 rx_valid low mid-word SHALL stall with no state change; partial word bytes are retained.

Reset
REQ-027 rst_n=0 at a rising edge -> IDLE; counters, checksum and assembled word cleared.
REQ-028 Reset values: rx_ready=0, imem_we=0, imem_addr=0, imem_wd=0, cpu_rst_n=0, busy=0, done=0, error=0.
REQ-029 Reset during a session SHALL abort it with no further writes; words already written are not rewritten.

Configuration
REQ-030 Macro IMEM_LOADER_CHECKSUM_EN selects end-of-load checksum.
REQ-031 Defined: checksum = XOR of all data bytes (length byte excluded); CHK accepts one byte; match -> DONE, mismatch -> ERR.
REQ-032 Not defined: CHK state is unreachable, no checksum byte is consumed, last WRITE (or N=0) -> DONE.

Verification
REQ-033 Reset, then N=1, bytes 20 08 00 05 (checksum 2D when enabled) -> one imem_we pulse, addr 0, wd 0x20080005; done=1, cpu_rst_n=1.
REQ-034 N=3 with gaps of 2 idle cycles in rx_valid -> writes at addr 0,1,2 in order, no write during gaps, data intact.
REQ-035 N=65 with IMEM_DEPTH=64 -> ERR the cycle after the length byte, no imem_we, error=1, cpu_rst_n=0.
REQ-036 Checksum enabled, N=1, bytes 00 00 00 01, checksum byte 00 -> ERR after write; with checksum 01 -> DONE.
REQ-037 rst_n=0 after the second byte of word 1 of N=2 -> only addr 0 written, all outputs at reset values, new start loads cleanly.
REQ-038 start pulsed in BYTE state -> ignored; start in DONE -> cpu_rst_n=0 next cycle, state LEN.
